lin_to_lns: RTL and testbench



---
 rtl/lns_pkg.sv | 25 ++
 rtl/lzc.sv | 31 +++
 rtl/lin_to_lns.sv | 194 +++++++++++++++++++
 tb/tb_lin_to_lns.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lns_pkg.sv
// lns_pkg
// Shared definitions for the LNS datapath blocks (encoder, decoder,
// adder/multiplier). The 12-bit LNS word is {sign, signed log2|x|}, where
// the 11-bit log field carries FRAC_BITS fractional bits. The code 12'h400
// (most negative log, positive sign) is reserved for linear zero, so real
// logs are clamped to [-1023, 1023].

package lns_pkg;

  localparam int LNS_W = 12;
  localparam int LOG_W = 11;

  localparam logic [LNS_W-1:0] LNS_ZERO = 12'h400;

  localparam int LOG_MAX = 1023;
  localparam int LOG_MIN = -1023;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    SQUARE,
    DONE
  } lns_state_e;

endpackage

// File: rtl/lzc.sv
// lzc
// Priority encoder reporting the index of the most significant set bit.
// Shared by the linear->LNS encoder and the future LNS->linear decoder.
//
// Ports:
//   i_data  : W-bit word to scan
//   o_pos   : index of the leading one (0 when i_data is zero)
//   o_valid : 1 when i_data has at least one bit set

module lzc #(
  parameter int W  = 16,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_data,
  output logic [PW-1:0] o_pos,
  output logic          o_valid
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    o_pos   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_pos   = PW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lin_to_lns.sv
// lin_to_lns
// Iterative encoder from signed two's-complement fixed-point linear values
// to the 12-bit LNS word. The integer part of log2|x| comes from the
// leading-one position; fractional bits come from repeated squaring of the
// normalised mantissa, one bit per cycle, MSB first.
//
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : input word valid
//   in_ready  : converter idle and able to accept a word
//   in_data   : signed linear value, IN_FRAC fractional bits
//   out_valid : result valid, held until out_ready
//   out_ready : downstream accepts the result
//   out_data  : {sign, signed log2|x| with FRAC_BITS fractional bits}
//
// Build option:
//   LNS_ROUND_EN : one extra squaring produces a guard bit and the result
//                  is rounded half-up (latency FRAC_BITS+3). Undefined,
//                  the fraction is truncated (latency FRAC_BITS+2).

module lin_to_lns
  import lns_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int IN_FRAC   = 8,
  parameter int FRAC_BITS = 5,
  parameter int MANT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LNS_W-1:0] out_data
);

`ifdef LNS_ROUND_EN
  localparam int ITERS = FRAC_BITS + 1;
`else
  localparam int ITERS = FRAC_BITS;
`endif

  localparam int PW     = $clog2(IN_W);
  localparam int CNT_W  = $clog2(ITERS + 1);
  localparam int LOGI_W = 16;
  localparam int SQT_W  = MANT_W + 1;

  localparam logic [PW-1:0] TOP_IDX = PW'(IN_W - 1);

  lns_state_e r_state;
  lns_state_e w_stateNext;

  logic                     r_sign;
  logic [IN_W-1:0]          r_mag;
  logic signed [LOGI_W-1:0] r_intLog;
  logic [MANT_W-1:0]        r_mant;
  logic [ITERS-1:0]         r_frac;
  logic [CNT_W-1:0]         r_cnt;
  logic [LNS_W-1:0]         r_outData;

  logic [IN_W-1:0]          w_absIn;
  logic [PW-1:0]            w_pos;
  logic                     w_lzValid;
  logic [PW-1:0]            w_shamt;
  logic [MANT_W-1:0]        w_mantNorm;
  logic signed [LOGI_W-1:0] w_intLogNorm;
  logic [2*MANT_W-1:0]      w_mantExt;
  logic [SQT_W-1:0]         w_sqTop;
  logic                     w_bit;
  logic [MANT_W-1:0]        w_mantNext;
  logic [ITERS-1:0]         w_fracNext;
  logic                     w_lastIter;
  logic signed [LOGI_W-1:0] w_logRaw;
  logic [LOG_W-1:0]         w_logField;

  // Magnitude of the input; 0x8000 maps to 32768 as an unsigned value.
  assign w_absIn = in_data[IN_W-1] ? (~in_data + 1'b1) : in_data;

  lzc #(
    .W  (IN_W),
    .PW (PW)
  ) u_lzc (
    .i_data  (r_mag),
    .o_pos   (w_pos),
    .o_valid (w_lzValid)
  );

  // Move the leading one to bit MANT_W-1 (mantissa in Q1.MANT_W-1).
  assign w_shamt      = TOP_IDX - w_pos;
  assign w_mantNorm   = MANT_W'(({r_mag, {MANT_W{1'b0}}} << w_shamt) >> IN_W);
  assign w_intLogNorm = $signed(LOGI_W'(w_pos)) - $signed(LOGI_W'(IN_FRAC));

  // Square is Q2.x; only bits from MANT_W-1 upward are ever kept, so the
  // product is pre-shifted down to its top MANT_W+1 bits.
  assign w_mantExt  = {{MANT_W{1'b0}}, r_mant};
  assign w_sqTop    = SQT_W'((w_mantExt * w_mantExt) >> (MANT_W - 1));
  assign w_bit      = w_sqTop[SQT_W-1];
  assign w_mantNext = w_bit ? w_sqTop[SQT_W-1:1] : w_sqTop[MANT_W-1:0];
  assign w_fracNext = ITERS'({r_frac, w_bit});
  assign w_lastIter = (r_cnt == CNT_W'(ITERS - 1));

`ifdef LNS_ROUND_EN
  // The guard bit is the LSB of the fraction shift register.
  assign w_logRaw = (r_intLog <<< FRAC_BITS)
                  + $signed(LOGI_W'(w_fracNext[ITERS-1:1]))
                  + $signed(LOGI_W'(w_fracNext[0]));
`else
  assign w_logRaw = (r_intLog <<< FRAC_BITS) + $signed(LOGI_W'(w_fracNext));
`endif

  // Clamp to the representable range; -1024 is the zero code, so the low
  // bound is -1023.
  always_comb begin
    w_logField = w_logRaw[LOG_W-1:0];
    if (w_logRaw > LOGI_W'(LOG_MAX)) begin
      w_logField = LOG_W'(LOG_MAX);
    end else if (w_logRaw < LOGI_W'(LOG_MIN)) begin
      w_logField = LOG_W'(LOG_MIN);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. DONE always returns to IDLE, so a new word is never
  // accepted in the same cycle the result leaves.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_stateNext = NORM;
      NORM:    w_stateNext = w_lzValid ? SQUARE : DONE;
      SQUARE:  if (w_lastIter) w_stateNext = DONE;
      DONE:    if (out_ready)  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath registers. The output word is loaded on the way into DONE and
  // is untouched while DONE waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_intLog  <= '0;
      r_mant    <= '0;
      r_frac    <= '0;
      r_cnt     <= '0;
      r_outData <= LNS_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= in_data[IN_W-1];
            r_mag  <= w_absIn;
          end
        end
        NORM: begin
          r_cnt  <= '0;
          r_frac <= '0;
          if (w_lzValid) begin
            r_intLog <= w_intLogNorm;
            r_mant   <= w_mantNorm;
          end else begin
            r_outData <= LNS_ZERO;
          end
        end
        SQUARE: begin
          r_mant <= w_mantNext;
          r_frac <= w_fracNext;
          r_cnt  <= r_cnt + 1'b1;
          if (w_lastIter) begin
            r_outData <= {r_sign, w_logField};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_outData;

endmodule

// File: tb/tb_lin_to_lns.sv
// tb_lin_to_lns
// Directed bench for lin_to_lns: hand-computed vectors from the datasheet
// examples, output hold under backpressure, reset mid-conversion, and a
// back-to-back stream scored against a real-valued floor(log2|x| * 32)
// model. Honours LNS_ROUND_EN when the design is built with it.

module tb_lin_to_lns;
  import lns_pkg::*;

`ifdef LNS_ROUND_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 7;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;

  int checkCount;
  int failCount;

  lin_to_lns dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Independent reference: floor(log2|x| * 32), or half-up rounding of the
  // 6-bit estimate when rounding is built in, then the zero/clamp rules.
  function automatic logic [11:0] modelLns(input logic [15:0] d);
    logic sgn;
    int   mag;
    real  lg;
    int   l;
    sgn = d[15];
    mag = sgn ? (65536 - int'(d)) : int'(d);
    if (mag == 0) return 12'h400;
    lg = $ln(real'(mag) / 256.0) / $ln(2.0);
`ifdef LNS_ROUND_EN
    l = int'($floor(lg * 64.0 + 1.0e-6));
    l = int'($floor((real'(l) + 1.0) / 2.0));
`else
    l = int'($floor(lg * 32.0 + 1.0e-6));
`endif
    if (l > 1023)  l = 1023;
    if (l < -1023) l = -1023;
    return {sgn, l[10:0]};
  endfunction

  // Sends one word, checks busy/latency/result, optionally holds off
  // out_ready for holdCycles cycles, then takes the result.
  task automatic applyStimulus(input string tag, input logic [15:0] data,
                               input logic [11:0] expData, input int expLat,
                               input int holdCycles);
    int waitCnt;
    int latency;
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'hA5A5;
    latency  = 1;
    while (!out_valid && latency < 40) begin
      checkOutput({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      latency++;
    end
    checkOutput({tag, "_latency"}, 32'(latency), 32'(expLat));
    checkOutput({tag, "_data"}, 32'(out_data), 32'(expData));
    for (int k = 0; k < holdCycles; k++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_data"}, 32'(out_data), 32'(expData));
      checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  logic [15:0] stream [12] = '{16'h0100, 16'h0200, 16'h0300, 16'h0500,
                               16'h0700, 16'hFF80, 16'h0001, 16'h8000,
                               16'h7FFF, 16'h8001, 16'h00C0, 16'hFF40};

  initial begin
    int stale;
    checkCount = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 16'h0000;
    out_ready  = 1'b0;
    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'h400);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Datasheet examples with hand-computed codes.
    applyStimulus("one",    16'h0100, 12'h000, LAT, 0);
    applyStimulus("two",    16'h0200, 12'h020, LAT, 0);
`ifdef LNS_ROUND_EN
    applyStimulus("three",  16'h0300, 12'h033, LAT, 0);
    applyStimulus("m0p75",  16'hFF40, 12'hFF3, LAT, 0);
`else
    applyStimulus("three",  16'h0300, 12'h032, LAT, 0);
    applyStimulus("m0p75",  16'hFF40, 12'hFF2, LAT, 0);
`endif
    applyStimulus("mhalf",  16'hFF80, 12'hFE0, LAT, 0);
    applyStimulus("lsb",    16'h0001, 12'h700, LAT, 0);
    applyStimulus("minneg", 16'h8000, 12'h8E0, LAT, 0);
    applyStimulus("zero_a", 16'h0000, 12'h400, 2, 0);
    applyStimulus("zero_b", 16'h0000, 12'h400, 2, 0);

    // Backpressure: result must sit still for 10 cycles.
    applyStimulus("hold", 16'h0200, 12'h020, LAT, 10);

    // Reset in the middle of SQUARE.
    in_valid = 1'b1;
    in_data  = 16'h0300;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_out_data", 32'(out_data), 32'h400);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checkOutput("no_stale_result", 32'(stale), 32'd0);
    checkOutput("post_reset_data", 32'(out_data), 32'h400);

    // Back-to-back stream against the real-valued model.
    foreach (stream[i]) begin
      applyStimulus("stream", stream[i], modelLns(stream[i]),
                    (stream[i] == 16'h0000) ? 2 : LAT, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
